// File: rtl/calc_cmd_arbiter_if.sv
// Keypad/calculator handshake bundle for calc_cmd_arbiter: two keypad request
// channels in, one command channel to the calculator out, plus lock status.
interface calc_cmd_arbiter_if;
    logic       req0;
    logic       req1;
    logic [3:0] cmd0;
    logic [3:0] cmd1;
    logic       ack0;
    logic       ack1;
    logic [1:0] calc_status;
    logic [3:0] cmd_out;
    logic       cmd_valid;
    logic       owner;
    logic       locked;
    logic       lock_timeout;

    modport slave (
        input  req0, req1, cmd0, cmd1, calc_status,
        output ack0, ack1, cmd_out, cmd_valid, owner, locked, lock_timeout
    );

    modport master (
        output req0, req1, cmd0, cmd1, calc_status,
        input  ack0, ack1, cmd_out, cmd_valid, owner, locked, lock_timeout
    );
endinterface

// File: rtl/calc_cmd_arbiter.sv
// Locks the calculator to one of two keypads and forwards its commands one per two cycles.
// Optional idle-lock revocation is built in when CALC_ARB_TIMEOUT_EN is defined.
module calc_cmd_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [3:0]  IDLE_CMD       = 4'b1101
) (
    input logic               clock,
    input logic               reset,
    calc_cmd_arbiter_if.slave bus
);
    localparam logic [1:0] ST_ERRO    = 2'd0;
    localparam logic [1:0] ST_PRONTA  = 2'd1;
    localparam logic [1:0] ST_OCUPADA = 2'd2;
    localparam logic [3:0] CMD_IGUAL  = 4'b1110;
    localparam logic [3:0] CMD_CLEAR  = 4'b1111;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        OWNED,
        WAIT_BUSY,
        WAIT_DONE,
        ERR_HOLD
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] cmd_out_q, cmd_out_nxt;
    logic       cmd_valid_q, cmd_valid_nxt;
    logic       ack0_q, ack0_nxt;
    logic       ack1_q, ack1_nxt;
    logic       owner_q, owner_nxt;
    logic       locked_q, locked_nxt;
    logic       rr_last, rr_last_nxt;
    logic [1:0] ready_run, ready_run_nxt;
    logic       release_lock;
    logic       take;
    logic       fwd;

    logic       own_req;
    logic       own_ack;
    logic [3:0] own_cmd;
    logic       owned_fwd;

    assign own_req   = owner_q ? bus.req1 : bus.req0;
    assign own_ack   = owner_q ? ack1_q   : ack0_q;
    assign own_cmd   = owner_q ? bus.cmd1 : bus.cmd0;
    // The registered ack is still high the cycle after a forward, which enforces the 2-cycle spacing.
    assign owned_fwd = (state == OWNED) && own_req && (bus.calc_status == ST_PRONTA) && !own_ack;

`ifdef CALC_ARB_TIMEOUT_EN
    localparam int unsigned     TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_cnt;
    logic          tmo_fire;
    logic          lock_timeout_q;

    assign tmo_fire = (state == OWNED) && (bus.calc_status != ST_ERRO) && !owned_fwd
                      && (tmo_cnt == TMO_LAST);

    // Counts only quiet OWNED cycles; held at zero everywhere else so entry into OWNED starts fresh.
    always_ff @(posedge clock) begin
        if (reset) begin
            tmo_cnt        <= '0;
            lock_timeout_q <= 1'b0;
        end else begin
            lock_timeout_q <= tmo_fire;
            if ((state != OWNED) || owned_fwd || tmo_fire || (bus.calc_status == ST_ERRO)) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    assign bus.lock_timeout = lock_timeout_q;
`else
    assign bus.lock_timeout = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        cmd_out_nxt   = IDLE_CMD;
        cmd_valid_nxt = 1'b0;
        ack0_nxt      = 1'b0;
        ack1_nxt      = 1'b0;
        owner_nxt     = owner_q;
        locked_nxt    = locked_q;
        rr_last_nxt   = rr_last;
        ready_run_nxt = ready_run;
        release_lock  = 1'b0;
        take          = 1'b0;
        fwd           = 1'b0;

        case (state)
            IDLE: begin
                if ((bus.calc_status == ST_PRONTA) && (bus.req0 || bus.req1)) begin
                    owner_nxt  = (bus.req0 && bus.req1) ? ~rr_last : bus.req1;
                    locked_nxt = 1'b1;
                    state_nxt  = OWNED;
                end
            end
            OWNED: begin
                if (bus.calc_status == ST_ERRO) begin
                    state_nxt = ERR_HOLD;
                end else if (owned_fwd) begin
                    take = 1'b1;
                    fwd  = 1'b1;
                    if (own_cmd == CMD_IGUAL) begin
                        state_nxt     = WAIT_BUSY;
                        ready_run_nxt = 2'd0;
                    end
                end
            end
            WAIT_BUSY: begin
                if (bus.calc_status == ST_OCUPADA) begin
                    state_nxt     = WAIT_DONE;
                    ready_run_nxt = 2'd0;
                end else if (bus.calc_status == ST_ERRO) begin
                    state_nxt     = ERR_HOLD;
                    ready_run_nxt = 2'd0;
                end else if (bus.calc_status == ST_PRONTA) begin
                    // The calculator may finish too fast to ever show OCUPADA.
                    if (ready_run == 2'd3) begin
                        release_lock = 1'b1;
                    end else begin
                        ready_run_nxt = ready_run + 2'd1;
                    end
                end else begin
                    ready_run_nxt = 2'd0;
                end
            end
            WAIT_DONE: begin
                if (bus.calc_status == ST_PRONTA) begin
                    release_lock = 1'b1;
                end else if (bus.calc_status == ST_ERRO) begin
                    state_nxt = ERR_HOLD;
                end
            end
            ERR_HOLD: begin
                // Only a clear reaches the calculator; anything else is swallowed so the keypad is not stuck.
                if (own_req && !own_ack) begin
                    take = 1'b1;
                    fwd  = (own_cmd == CMD_CLEAR);
                end
                if (bus.calc_status == ST_PRONTA) begin
                    state_nxt = OWNED;
                end
            end
            default: begin
                state_nxt  = IDLE;
                locked_nxt = 1'b0;
            end
        endcase

`ifdef CALC_ARB_TIMEOUT_EN
        if (tmo_fire) begin
            release_lock = 1'b1;
        end
`endif

        if (release_lock) begin
            locked_nxt  = 1'b0;
            state_nxt   = IDLE;
            rr_last_nxt = owner_q;
        end
        if (take) begin
            ack0_nxt = ~owner_q;
            ack1_nxt = owner_q;
        end
        if (fwd) begin
            cmd_out_nxt   = own_cmd;
            cmd_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cmd_out_q   <= IDLE_CMD;
            cmd_valid_q <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            owner_q     <= 1'b0;
            locked_q    <= 1'b0;
            rr_last     <= 1'b1;
            ready_run   <= 2'd0;
        end else begin
            state       <= state_nxt;
            cmd_out_q   <= cmd_out_nxt;
            cmd_valid_q <= cmd_valid_nxt;
            ack0_q      <= ack0_nxt;
            ack1_q      <= ack1_nxt;
            owner_q     <= owner_nxt;
            locked_q    <= locked_nxt;
            rr_last     <= rr_last_nxt;
            ready_run   <= ready_run_nxt;
        end
    end

    assign bus.cmd_out   = cmd_out_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.owner     = owner_q;
    assign bus.locked    = locked_q;
endmodule

// File: tb/tb_calc_cmd_arbiter.sv
// Bench for calc_cmd_arbiter: directed scenarios then random keypad/calculator traffic,
// every cycle compared against a transaction-level reference model.
module tb_calc_cmd_arbiter;
    localparam logic [3:0] IDLE = 4'b1101;
    localparam int         TMO  = 8;
    localparam int P_FREE = 0, P_HELD = 1, P_AFTER_EQ = 2, P_COMPUTING = 3, P_ERROR = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    calc_cmd_arbiter_if bus ();

    calc_cmd_arbiter #(.TIMEOUT_CYCLES(TMO), .IDLE_CMD(IDLE)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int       m_phase, m_own, m_last, m_quiet, m_ready_run;
    bit       m_locked, m_valid, m_pulse;
    bit [3:0] m_out;
    bit       m_ack [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_release();
        m_locked = 1'b0;
        m_phase  = P_FREE;
        m_last   = m_own;
    endtask

    // One clock edge of behaviour, derived from the inputs present at that edge.
    task automatic model_step();
        bit       r [2];
        bit [3:0] c [2];
        int       st;
        bit [3:0] out;
        bit       valid, pulse;
        bit       ack [2];
        r[0] = bus.req0; r[1] = bus.req1;
        c[0] = bus.cmd0; c[1] = bus.cmd1;
        st = int'(bus.calc_status);
        out = IDLE; valid = 0; pulse = 0; ack[0] = 0; ack[1] = 0;
        if (reset) begin
            m_phase = P_FREE; m_own = 0; m_locked = 0; m_last = 1; m_quiet = 0; m_ready_run = 0;
        end else begin
            case (m_phase)
                P_FREE: if (st == 1 && (r[0] || r[1])) begin
                    m_own    = (r[0] && r[1]) ? 1 - m_last : (r[1] ? 1 : 0);
                    m_locked = 1;
                    m_phase  = P_HELD;
                    m_quiet  = 0;
                end
                P_HELD: begin
                    if (st == 0) begin
                        m_phase = P_ERROR;
                    end else if (r[m_own] && st == 1 && !m_ack[m_own]) begin
                        out = c[m_own]; valid = 1; ack[m_own] = 1; m_quiet = 0;
                        if (c[m_own] == 4'hE) begin
                            m_phase = P_AFTER_EQ; m_ready_run = 0;
                        end
                    end else begin
                        m_quiet++;
`ifdef CALC_ARB_TIMEOUT_EN
                        if (m_quiet >= TMO) begin
                            pulse = 1;
                            model_release();
                        end
`endif
                    end
                end
                P_AFTER_EQ: begin
                    if (st == 2) m_phase = P_COMPUTING;
                    else if (st == 0) m_phase = P_ERROR;
                    else if (st == 1) begin
                        m_ready_run++;
                        if (m_ready_run == 4) model_release();
                    end else m_ready_run = 0;
                end
                P_COMPUTING: begin
                    if (st == 1) model_release();
                    else if (st == 0) m_phase = P_ERROR;
                end
                P_ERROR: begin
                    if (r[m_own] && !m_ack[m_own]) begin
                        ack[m_own] = 1;
                        if (c[m_own] == 4'hF) begin
                            out = c[m_own]; valid = 1;
                        end
                    end
                    if (st == 1) begin
                        m_phase = P_HELD; m_quiet = 0;
                    end
                end
                default: m_phase = P_FREE;
            endcase
        end
        m_out = out; m_valid = valid; m_pulse = pulse; m_ack[0] = ack[0]; m_ack[1] = ack[1];
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        chk("cmd_out",      32'(bus.cmd_out),      32'(m_out));
        chk("cmd_valid",    32'(bus.cmd_valid),    32'(m_valid));
        chk("ack0",         32'(bus.ack0),         32'(m_ack[0]));
        chk("ack1",         32'(bus.ack1),         32'(m_ack[1]));
        chk("owner",        32'(bus.owner),        32'(m_own));
        chk("locked",       32'(bus.locked),       32'(m_locked));
        chk("lock_timeout", 32'(bus.lock_timeout), 32'(m_pulse));
        // Keypads hold their request until acknowledged.
        if (bus.ack0) bus.req0 = 1'b0;
        if (bus.ack1) bus.req1 = 1'b0;
    endtask

    function automatic logic [3:0] rand_cmd();
        int k = $urandom_range(0, 7);
        if (k < 2) return 4'hE;
        if (k == 2) return 4'hF;
        return 4'($urandom_range(0, 13));
    endfunction

    initial begin
        bit seen;
        bus.req0 = 0; bus.req1 = 0; bus.cmd0 = 0; bus.cmd1 = 0; bus.calc_status = 2'd1;
        reset = 1;
        tick(); tick();
        chk("rst_cmd_out", 32'(bus.cmd_out), 32'hD);
        chk("rst_valid",   32'(bus.cmd_valid), 0);
        chk("rst_locked",  32'(bus.locked), 0);
        chk("rst_owner",   32'(bus.owner), 0);
        chk("rst_acks",    32'({bus.ack0, bus.ack1}), 0);
        chk("rst_tmo",     32'(bus.lock_timeout), 0);

        // Single request: grant, forward, return to idle code.
        reset = 0; bus.req0 = 1; bus.cmd0 = 4'd3;
        tick();
        chk("r29_owner", 32'(bus.owner), 0);
        chk("r29_locked", 32'(bus.locked), 1);
        chk("r29_grant_valid", 32'(bus.cmd_valid), 0);
        tick();
        chk("r29_cmd", 32'(bus.cmd_out), 3);
        chk("r29_valid", 32'(bus.cmd_valid), 1);
        chk("r29_ack0", 32'(bus.ack0), 1);
        tick();
        chk("r29_idle_cmd", 32'(bus.cmd_out), 32'hD);
        chk("r29_ack0_off", 32'(bus.ack0), 0);

        // Simultaneous requests, Igual, busy/done, hand-over to the other keypad.
        reset = 1; tick(); reset = 0;
        bus.req0 = 1; bus.cmd0 = 4'hE; bus.req1 = 1; bus.cmd1 = 4'd5;
        tick();
        chk("r30_owner0", 32'(bus.owner), 0);
        tick();
        chk("r30_igual", 32'(bus.cmd_out), 32'hE);
        bus.calc_status = 2'd2; tick();
        bus.calc_status = 2'd1; tick();
        chk("r30_released", 32'(bus.locked), 0);
        tick();
        chk("r30_owner1", 32'(bus.owner), 1);
        chk("r30_relock", 32'(bus.locked), 1);
        tick();
        chk("r30_fwd1", 32'(bus.cmd_out), 5);
        chk("r30_ack1", 32'(bus.ack1), 1);

        // Non-owner is starved while the owner keeps the lock.
        reset = 1; tick(); reset = 0;
        bus.req1 = 0; bus.req0 = 1; bus.cmd0 = 4'd2;
        tick(); tick();
        bus.req1 = 1; bus.cmd1 = 4'd5;
        for (int i = 0; i < 50; i++) begin
            if (i % 4 == 0 && !bus.req0) begin bus.req0 = 1; bus.cmd0 = 4'd2; end
            tick();
            chk("r31_ack1", 32'(bus.ack1), 0);
            if (bus.cmd_valid) chk("r31_cmd", 32'(bus.cmd_out), 2);
        end
        for (int i = 0; i < 4 && bus.req0; i++) tick();

        // No forwarding while the calculator computes.
        bus.req0 = 1; bus.cmd0 = 4'hE;
        seen = 0;
        for (int i = 0; i < 4 && !seen; i++) begin
            tick();
            if (bus.cmd_valid) seen = 1;
        end
        chk("r32_igual", 32'(bus.cmd_out), 32'hE);
        bus.calc_status = 2'd2; bus.req0 = 1; bus.cmd0 = 4'd3;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("r32_ack0", 32'(bus.ack0), 0);
            chk("r32_valid", 32'(bus.cmd_valid), 0);
        end
        bus.calc_status = 2'd1; tick();
        chk("r32_released", 32'(bus.locked), 0);
        repeat (6) tick();

        // Error hold: drop ordinary codes, pass clear, resume on ready.
        reset = 1; tick(); reset = 0;
        bus.req0 = 1; bus.cmd0 = 4'd4; bus.req1 = 0;
        tick(); tick();
        bus.calc_status = 2'd0; tick();
        chk("r33_locked_err", 32'(bus.locked), 1);
        bus.req0 = 1; bus.cmd0 = 4'd7; tick();
        chk("r33_drop_ack", 32'(bus.ack0), 1);
        chk("r33_drop_valid", 32'(bus.cmd_valid), 0);
        chk("r33_drop_cmd", 32'(bus.cmd_out), 32'hD);
        tick();
        bus.req0 = 1; bus.cmd0 = 4'hF; tick();
        chk("r33_clear_cmd", 32'(bus.cmd_out), 32'hF);
        chk("r33_clear_valid", 32'(bus.cmd_valid), 1);
        bus.calc_status = 2'd1; tick();
        chk("r33_still_locked", 32'(bus.locked), 1);
        bus.req0 = 1; bus.cmd0 = 4'd6; tick();
        chk("r33_owned_valid", 32'(bus.cmd_valid), 1);
        chk("r33_owned_cmd", 32'(bus.cmd_out), 6);

        // Idle owner: revoked only when the timeout is built in.
        reset = 1; tick(); reset = 0;
        bus.req0 = 1; bus.cmd0 = 4'd1;
        tick(); tick();
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk("r34_hold", 32'(bus.locked), 1);
            chk("r34_no_pulse", 32'(bus.lock_timeout), 0);
        end
        tick();
`ifdef CALC_ARB_TIMEOUT_EN
        chk("r34_pulse", 32'(bus.lock_timeout), 1);
        chk("r34_release", 32'(bus.locked), 0);
        tick();
        chk("r34_pulse_end", 32'(bus.lock_timeout), 0);
`else
        chk("r34_no_timeout", 32'(bus.lock_timeout), 0);
        repeat (4) tick();
        chk("r34_held", 32'(bus.locked), 1);
`endif

        // Random traffic from both keypads with a wandering calculator status.
        for (int k = 0; k < 3000; k++) begin
            if (!bus.req0 && $urandom_range(0, 3) == 0) begin bus.req0 = 1; bus.cmd0 = rand_cmd(); end
            if (!bus.req1 && $urandom_range(0, 3) == 0) begin bus.req1 = 1; bus.cmd1 = rand_cmd(); end
            if ($urandom_range(0, 7) == 0) begin
                int s = $urandom_range(0, 7);
                bus.calc_status = (s == 0) ? 2'd0 : ((s < 4) ? 2'd2 : 2'd1);
            end
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
